mc_pingpong_frame_buffer: RTL and testbench
===========================================

Name: mc_pingpong_frame_buffer

Overview:
Parametrised successor to the single-stream ping-pong input buffer. It sits between the sample source and the controller, FIR and FFT engines. It de-interleaves a multi-channel sample stream into frames of BLOCK_SIZE samples per channel across two banks. It hands complete frames to the consumer with a ready/ack handshake, applies backpressure when both banks are occupied, and supports flush, a random-access read port and drop accounting.

Parameters:
DATA_WIDTH, 16, sample width in bits
BLOCK_SIZE, 16, samples per channel per frame (power of 2, >=2)
NUM_CH, 2, interleaved channels (>=1)
CNT_WIDTH, 16, width of the frame and drop counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
valid_in  in  1  sample_in valid this cycle
sample_in  in  DATA_WIDTH  interleaved sample stream: ch0, ch1, ..., ch(NUM_CH-1), ch0, ...
in_ready  out  1  buffer can accept a sample this cycle
flush  in  1  discard the partial frame in the write bank
frame_ready  out  1  a complete frame is available in ready_bank
ready_bank  out  1  bank index holding the ready frame
frame_ack  in  1  consumer has finished with the ready frame
rd_en  in  1  read request
rd_ch  in  CH_W  read channel, CH_W = max(1, clog2(NUM_CH))
rd_idx  in  IDX_W  read sample index, IDX_W = clog2(BLOCK_SIZE)
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data valid
overflow  out  1  sticky: at least one sample was dropped
drop_count  out  CNT_WIDTH  count of dropped samples, saturating
frame_count  out  CNT_WIDTH  frames completed, wrapping

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: wr_bank=0, wr_ptr=0, state=FILL, in_ready=1, frame_ready=0, ready_bank=0, rd_data=0, rd_valid=0, overflow=0, drop_count=0, frame_count=0. Memory contents are not reset.
- Frame length FRAME = NUM_CH*BLOCK_SIZE. wr_ptr ranges 0..FRAME-1.
  - Accepted sample goes to channel wr_ptr mod NUM_CH, index wr_ptr div NUM_CH, in bank wr_bank.
- Accept condition: valid_in && in_ready. in_ready = (state==FILL) && !reset.
- States: FILL, HOLD.
- FILL, accept with wr_ptr<FRAME-1: wr_ptr++.
- FILL, accept with wr_ptr==FRAME-1 (frame completes):
  - If frame_ready==0, or frame_ack is high this cycle: next cycle frame_ready=1, ready_bank=wr_bank, wr_bank flips, wr_ptr=0, frame_count++. State stays FILL.
  - Otherwise: state goes to HOLD and wr_ptr stays at FRAME-1 (frame complete but not published).
- HOLD: in_ready=0.
  - On frame_ack: publish the held bank in the same way (frame_ready stays 1, ready_bank=held bank, wr_bank flips, wr_ptr=0, frame_count++) and return to FILL. in_ready goes high the cycle after the ack.
- frame_ack while frame_ready==1 and no publish that cycle: frame_ready=0 next cycle.
- frame_ack while frame_ready==0: ignored.
- Drop: valid_in && !in_ready sets overflow and increments drop_count. drop_count saturates at all-ones. Only reset clears either.
- flush:
  - In FILL: wr_ptr=0. Any sample arriving the same cycle is discarded, not counted as a drop, and wr_ptr stays 0.
  - In HOLD: ignored; the held frame is complete.
  - Never affects frame_ready or ready_bank.
- Read port: 1-cycle latency.
  - rd_en with frame_ready==1: next cycle rd_data = mem[ready_bank][rd_ch][rd_idx], rd_valid=1.
  - rd_en with frame_ready==0: rd_valid=0, rd_data holds its value.
  - No rd_en: rd_valid=0.
  - rd_ch >= NUM_CH: rd_data=0, rd_valid=1.
- Read and write always target different banks, so there is no read/write hazard.
- Reset mid-frame or in HOLD: all partial and held data is abandoned and outputs return to reset values the next cycle.

Decomposition:
- Package mc_pingpong_pkg holds:
  - the state enum (FILL, HOLD),
  - functions frame_len(NUM_CH, BLOCK_SIZE) and ch_width(NUM_CH).
- One sub-module, pingpong_bank_ram: two banks of NUM_CH*BLOCK_SIZE x DATA_WIDTH, one synchronous write port, one registered read port.
- The top level contains the FSM, pointers, handshake and counters.

Test Plan:
Use NUM_CH=2, BLOCK_SIZE=4 (FRAME=8).
1. Reset, then stream samples 1..8 continuously -> frame_ready rises 1 cycle after sample 8; ready_bank=0, frame_count=1. Reads give (ch0, idx0)=1, (ch1, idx0)=2, (ch0, idx3)=7, (ch1, idx3)=8, each with rd_valid 1 cycle after rd_en.
2. Stream samples 1..16 with no ack -> HOLD after sample 16 and in_ready=0. Samples 17..19 drop: drop_count=3, overflow=1. Ack -> ready_bank=1, (ch0, idx0)=9, in_ready=1 on the next cycle.
3. frame_ack in the same cycle as the final sample of frame 2 -> no HOLD; frame_ready stays 1, ready_bank changes 0->1, frame_count=2, no drops.
4. Stream 5 samples, pulse flush, stream 8 more (100..107) -> first frame contains 100..107; drop_count=0.
5. rd_en with frame_ready=0 -> rd_valid=0. Reset asserted during HOLD -> all outputs at reset values next cycle; a fresh 8-sample frame publishes to bank 0.
6. Drive 70000 drops with CNT_WIDTH=16 -> drop_count saturates at 65535.

Source files
------------

// File: rtl/mc_pingpong_pkg.sv
// Shared types and elaboration helpers for the multi-channel ping-pong frame buffer.
package mc_pingpong_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int unsigned frame_len(input int unsigned num_ch, input int unsigned block_size);
        return num_ch * block_size;
    endfunction

    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/pingpong_bank_ram.sv
// Two-bank sample store: one synchronous write port, one registered read port.
module pingpong_bank_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_bank,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_WIDTH-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/mc_pingpong_frame_buffer.sv
// De-interleaves a multi-channel sample stream into ping-pong frames and hands
// complete frames to a consumer through a ready/ack handshake.
module mc_pingpong_frame_buffer
    import mc_pingpong_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned BLOCK_SIZE = 16,
    parameter  int unsigned NUM_CH     = 2,
    parameter  int unsigned CNT_WIDTH  = 16,
    localparam int unsigned CH_W       = ch_width(NUM_CH),
    localparam int unsigned IDX_W      = $clog2(BLOCK_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  frame_ready,
    output logic                  ready_bank,
    input  logic                  frame_ack,
    input  logic                  rd_en,
    input  logic [CH_W-1:0]       rd_ch,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    localparam int unsigned FRAME = frame_len(NUM_CH, BLOCK_SIZE);
    localparam int unsigned PTR_W = $clog2(FRAME);

    state_t                 state, state_n;
    logic                   wr_bank, wr_bank_n;
    logic [PTR_W-1:0]       wr_ptr, wr_ptr_n;
    logic [CH_W-1:0]        wr_ch, wr_ch_n;
    logic [IDX_W-1:0]       wr_idx, wr_idx_n;
    logic                   frame_ready_n, ready_bank_n;
    logic [CNT_WIDTH-1:0]   frame_count_n;
    logic                   accept, wr_en, last, publish;
    logic                   rd_fire, rd_null;
    logic [(1<<CH_W)-1:0]   ch_present;
    logic [DATA_WIDTH-1:0]  ram_q;

    assign in_ready = (state == FILL) && !reset;
    assign accept   = valid_in && in_ready;
    assign wr_en    = accept && !flush;
    assign last     = (wr_ptr == PTR_W'(FRAME - 1));

    // wr_ch/wr_idx shadow wr_ptr as (ptr mod NUM_CH, ptr div NUM_CH) without a divider.
    always_comb begin
        state_n       = state;
        wr_bank_n     = wr_bank;
        wr_ptr_n      = wr_ptr;
        wr_ch_n       = wr_ch;
        wr_idx_n      = wr_idx;
        frame_ready_n = frame_ready;
        ready_bank_n  = ready_bank;
        frame_count_n = frame_count;
        publish       = 1'b0;
        case (state)
            FILL: begin
                if (flush) begin
                    wr_ptr_n = '0;
                    wr_ch_n  = '0;
                    wr_idx_n = '0;
                end else if (accept) begin
                    if (!last) begin
                        wr_ptr_n = wr_ptr + 1'b1;
                        if (wr_ch == CH_W'(NUM_CH - 1)) begin
                            wr_ch_n  = '0;
                            wr_idx_n = wr_idx + 1'b1;
                        end else begin
                            wr_ch_n = wr_ch + 1'b1;
                        end
                    end else if (!frame_ready || frame_ack) begin
                        publish = 1'b1;
                    end else begin
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    publish = 1'b1;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase

        if (publish) begin
            frame_ready_n = 1'b1;
            ready_bank_n  = wr_bank;
            wr_bank_n     = ~wr_bank;
            wr_ptr_n      = '0;
            wr_ch_n       = '0;
            wr_idx_n      = '0;
            frame_count_n = frame_count + 1'b1;
        end else if (frame_ack && frame_ready) begin
            frame_ready_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            wr_bank     <= 1'b0;
            wr_ptr      <= '0;
            wr_ch       <= '0;
            wr_idx      <= '0;
            frame_ready <= 1'b0;
            ready_bank  <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            wr_bank     <= wr_bank_n;
            wr_ptr      <= wr_ptr_n;
            wr_ch       <= wr_ch_n;
            wr_idx      <= wr_idx_n;
            frame_ready <= frame_ready_n;
            ready_bank  <= ready_bank_n;
            frame_count <= frame_count_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (valid_in && !in_ready) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    always_comb begin
        ch_present = '0;
        for (int unsigned i = 0; i < (1 << CH_W); i++) begin
            ch_present[i] = (i < NUM_CH);
        end
    end

    assign rd_fire = rd_en && frame_ready;

    // rd_null masks the RAM register so rd_data reads zero after reset and for absent channels.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_null  <= 1'b1;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_null <= !ch_present[rd_ch];
            end
        end
    end

    assign rd_data = rd_null ? '0 : ram_q;

    pingpong_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (CH_W + IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr ({wr_ch, wr_idx}),
        .wr_data (sample_in),
        .rd_en   (rd_fire && ch_present[rd_ch]),
        .rd_bank (ready_bank),
        .rd_addr ({rd_ch, rd_idx}),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_mc_pingpong_frame_buffer.sv
// Self-checking bench for mc_pingpong_frame_buffer with NUM_CH=2, BLOCK_SIZE=4.
module tb_mc_pingpong_frame_buffer;

    localparam int DW  = 16;
    localparam int BS  = 4;
    localparam int NCH = 2;
    localparam int FR  = NCH * BS;
    localparam int CW  = 16;
    localparam int VW  = 5 + DW + 2 * CW;

    logic          clk = 1'b0;
    logic          reset, valid_in, flush, frame_ack, rd_en;
    logic [DW-1:0] sample_in;
    logic [0:0]    rd_ch;
    logic [1:0]    rd_idx;
    logic          in_ready, frame_ready, ready_bank, rd_valid, overflow;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] drop_count, frame_count;

    always #5 clk = ~clk;

    mc_pingpong_frame_buffer #(
        .DATA_WIDTH (DW),
        .BLOCK_SIZE (BS),
        .NUM_CH     (NCH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .sample_in   (sample_in),
        .in_ready    (in_ready),
        .flush       (flush),
        .frame_ready (frame_ready),
        .ready_bank  (ready_bank),
        .frame_ack   (frame_ack),
        .rd_en       (rd_en),
        .rd_ch       (rd_ch),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .frame_count (frame_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: frames stored as flat sample lists, position p = idx*NCH + ch.
    bit            m_hold, m_fr, m_rb, m_wb, m_ovf, m_rv;
    int            m_ptr, m_drop, m_fc;
    logic [DW-1:0] m_rd;
    logic [DW-1:0] m_mem [2][FR];

    function automatic logic [VW-1:0] dut_vec();
        return {in_ready, frame_ready, ready_bank, rd_valid, rd_data, overflow, drop_count, frame_count};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [CW-1:0] d;
        d = (m_drop > 65535) ? '1 : CW'(m_drop);
        return {!m_hold && !reset, m_fr, m_rb, m_rv, m_rd, m_ovf, d, CW'(m_fc)};
    endfunction

    task automatic tick();
        bit pub;
        @(posedge clk);
        if (reset) begin
            m_hold = 0; m_fr = 0; m_rb = 0; m_wb = 0; m_ovf = 0; m_rv = 0;
            m_ptr = 0; m_drop = 0; m_fc = 0; m_rd = '0;
        end else begin
            if (rd_en && m_fr) begin
                m_rv = 1;
                m_rd = (int'(rd_ch) < NCH) ? m_mem[m_rb][int'(rd_idx) * NCH + int'(rd_ch)] : '0;
            end else begin
                m_rv = 0;
            end
            pub = 0;
            if (m_hold) begin
                if (valid_in) begin
                    m_ovf = 1;
                    m_drop++;
                end
                if (frame_ack) begin
                    pub = 1;
                    m_hold = 0;
                end
            end else if (flush) begin
                m_ptr = 0;
            end else if (valid_in) begin
                m_mem[m_wb][m_ptr] = sample_in;
                if (m_ptr < FR - 1) m_ptr++;
                else if (!m_fr || frame_ack) pub = 1;
                else m_hold = 1;
            end
            if (pub) begin
                m_fr = 1; m_rb = m_wb; m_wb = !m_wb; m_ptr = 0; m_fc++;
            end else if (frame_ack && m_fr) begin
                m_fr = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        valid_in = 0; flush = 0; frame_ack = 0; rd_en = 0;
        sample_in = '0; rd_ch = '0; rd_idx = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic stream(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            valid_in  = 1;
            sample_in = DW'(first + i);
            tick();
        end
        valid_in = 0;
    endtask

    task automatic test_reset();
        logic [VW-1:0] exp_v;
        idle();
        reset = 1;
        tick();
        tick();
        exp_v = '0;
        if (dut_vec() !== exp_v) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), exp_v);
        end
        n_cmp++;
        reset = 0;
        #1;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_cmp++;
    endtask

    task automatic test_single_frame();
        int rc [4] = '{0, 1, 0, 1};
        int ri [4] = '{0, 0, 3, 3};
        int rv [4] = '{1, 2, 7, 8};
        do_reset();
        stream(1, 7);
        if (frame_ready !== 1'b0) begin
            n_err++;
            $display("FAIL early_frame_ready: got %b expected 0", frame_ready);
        end
        n_cmp++;
        stream(8, 1);
        if ({frame_ready, ready_bank, frame_count} !== {1'b1, 1'b0, CW'(1)}) begin
            n_err++;
            $display("FAIL frame1_publish: got fr=%b rb=%b fc=%0d expected fr=1 rb=0 fc=1",
                     frame_ready, ready_bank, frame_count);
        end
        n_cmp++;
        for (int k = 0; k < 4; k++) begin
            rd_en = 1; rd_ch = 1'(rc[k]); rd_idx = 2'(ri[k]);
            tick();
            if ({rd_valid, rd_data} !== {1'b1, DW'(rv[k])}) begin
                n_err++;
                $display("FAIL frame1_read[%0d]: got v=%b d=%0d expected v=1 d=%0d", k, rd_valid, rd_data, rv[k]);
            end
            n_cmp++;
        end
        rd_en = 0;
        tick();
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_valid_idle: got %b expected 0", rd_valid);
        end
        n_cmp++;
    endtask

    task automatic test_hold();
        do_reset();
        stream(1, 16);
        if (in_ready !== 1'b0 || dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL hold_entry: got in_ready=%b vec=%h expected in_ready=0 vec=%h", in_ready, dut_vec(), model_vec());
        end
        n_cmp++;
        stream(17, 3);
        if ({overflow, drop_count} !== {1'b1, CW'(3)}) begin
            n_err++;
            $display("FAIL hold_drops: got ovf=%b drops=%0d expected ovf=1 drops=3", overflow, drop_count);
        end
        n_cmp++;
        frame_ack = 1;
        tick();
        frame_ack = 0;
        if ({in_ready, frame_ready, ready_bank, frame_count} !== {3'b111, CW'(2)}) begin
            n_err++;
            $display("FAIL hold_release: got rdy=%b fr=%b rb=%b fc=%0d expected rdy=1 fr=1 rb=1 fc=2",
                     in_ready, frame_ready, ready_bank, frame_count);
        end
        n_cmp++;
        rd_en = 1; rd_ch = 0; rd_idx = 0;
        tick();
        rd_en = 0;
        if ({rd_valid, rd_data} !== {1'b1, DW'(9)}) begin
            n_err++;
            $display("FAIL hold_read: got v=%b d=%0d expected v=1 d=9", rd_valid, rd_data);
        end
        n_cmp++;
    endtask

    task automatic test_ack_same_cycle();
        do_reset();
        stream(1, 8);
        stream(9, 7);
        valid_in = 1; sample_in = 16; frame_ack = 1;
        tick();
        idle();
        if ({in_ready, frame_ready, ready_bank, frame_count, drop_count} !== {3'b111, CW'(2), CW'(0)}) begin
            n_err++;
            $display("FAIL ack_same_cycle: got rdy=%b fr=%b rb=%b fc=%0d drops=%0d expected 1 1 1 2 0",
                     in_ready, frame_ready, ready_bank, frame_count, drop_count);
        end
        n_cmp++;
    endtask

    task automatic test_flush();
        do_reset();
        stream(1, 5);
        flush = 1; valid_in = 1; sample_in = 999;
        tick();
        idle();
        stream(100, 8);
        if ({frame_ready, ready_bank, frame_count, drop_count} !== {2'b10, CW'(1), CW'(0)}) begin
            n_err++;
            $display("FAIL flush_publish: got fr=%b rb=%b fc=%0d drops=%0d expected 1 0 1 0",
                     frame_ready, ready_bank, frame_count, drop_count);
        end
        n_cmp++;
        for (int p = 0; p < FR; p++) begin
            rd_en = 1; rd_ch = 1'(p % NCH); rd_idx = 2'(p / NCH);
            tick();
            if ({rd_valid, rd_data} !== {1'b1, DW'(100 + p)}) begin
                n_err++;
                $display("FAIL flush_read[%0d]: got v=%b d=%0d expected v=1 d=%0d", p, rd_valid, rd_data, 100 + p);
            end
            n_cmp++;
        end
        rd_en = 0;
    endtask

    task automatic test_read_idle_and_reset();
        do_reset();
        rd_en = 1;
        tick();
        rd_en = 0;
        if ({rd_valid, rd_data} !== {1'b0, DW'(0)}) begin
            n_err++;
            $display("FAIL read_not_ready: got v=%b d=%0d expected v=0 d=0", rd_valid, rd_data);
        end
        n_cmp++;
        stream(1, 16);
        reset = 1;
        tick();
        if (dut_vec() !== {VW{1'b0}}) begin
            n_err++;
            $display("FAIL reset_in_hold: got %h expected 0", dut_vec());
        end
        n_cmp++;
        reset = 0;
        stream(50, 8);
        rd_en = 1; rd_ch = 1; rd_idx = 3;
        tick();
        rd_en = 0;
        if ({frame_ready, ready_bank, frame_count, rd_valid, rd_data} !== {2'b10, CW'(1), 1'b1, DW'(57)}) begin
            n_err++;
            $display("FAIL fresh_after_reset: got fr=%b rb=%b fc=%0d v=%b d=%0d expected 1 0 1 1 57",
                     frame_ready, ready_bank, frame_count, rd_valid, rd_data);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            valid_in  = ($urandom_range(0, 3) != 0);
            sample_in = DW'($urandom);
            flush     = ($urandom_range(0, 39) == 0);
            frame_ack = ($urandom_range(0, 7) == 0);
            rd_en     = ($urandom_range(0, 1) == 1);
            rd_ch     = 1'($urandom_range(0, 1));
            rd_idx    = 2'($urandom_range(0, 3));
            tick();
            if (dut_vec() !== model_vec()) begin
                n_err++;
                $display("FAIL random[%0d]: got %h expected %h", c, dut_vec(), model_vec());
            end
            n_cmp++;
        end
        idle();
        reset = 0;
    endtask

    task automatic test_drop_saturate();
        do_reset();
        stream(1, 16);
        valid_in = 1;
        repeat (70000) tick();
        valid_in = 0;
        if ({overflow, drop_count} !== {1'b1, 16'hFFFF} || dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL drop_saturate: got ovf=%b drops=%0d expected ovf=1 drops=65535", overflow, drop_count);
        end
        n_cmp++;
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_single_frame();
        test_hold();
        test_ack_same_cycle();
        test_flush();
        test_read_idle_and_reset();
        test_random();
        test_drop_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
